sync_pool_readout: RTL and testbench

//  Read-side consumer of the triple-buffered pooled-graph memory that sync max-pool fills.
//  On every buffer-pointer advance, scans the just-completed buffer linearly (addr 0..OUT_GRAPH_SIZE^2-1).

---
 rtl/sync_pool_readout.sv | 256 +++++++++++++++++++++++++
 tb/tb_sync_pool_readout.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_pool_readout.sv
// ---------------------------------------------------------------------------
// sync_pool_readout
//
// Read side of the triple-buffered pooled-graph memory that the sync max-pool
// stage fills. Each time the writer moves on to a new buffer, the buffer it
// just finished is scanned linearly from address 0 to OUT_GRAPH_SIZE^2-1.
// Every word is cleared in the same READ_FIRST access. Words whose edge bit 4
// is set are pushed through a small FIFO onto a valid/ready stream that feeds
// the next graph-conv layer.
//
// Ports
//   clk, reset        clock; synchronous active-high reset
//   wr_mem_ptr_i      buffer currently owned by the writer (0..2)
//   read_i            memory read data, READ_LATENCY cycles after ena_o
//   addr_o            memory address
//   ena_o, wea_o      memory enable / write enable (clear on every access)
//   write_o           memory write data, always zero
//   rd_mem_ptr_o      buffer being scanned
//   out_valid_o       stream handshake valid
//   out_ready_i       stream handshake ready
//   out_addr_o        node address of the emitted word
//   out_edges_o       edge bits of the emitted word
//   out_features_o    features of the emitted word (two's complement, [f])
//   busy_o            scan or drain in progress
//   frame_done_o      one-cycle pulse once a buffer is scanned and drained
//   overrun_o         one-cycle pulse when a pointer advance is dropped
// ---------------------------------------------------------------------------
module sync_pool_readout #(
    parameter int OUT_GRAPH_SIZE = 16,
    parameter int PRECISION      = 16,
    parameter int INPUT_DIM      = 32,
    parameter int ADDR_WIDTH     = $clog2(OUT_GRAPH_SIZE * OUT_GRAPH_SIZE),
    parameter int DATA_WIDTH     = INPUT_DIM * PRECISION + 18,
    parameter int READ_LATENCY   = 2,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [1:0]                           wr_mem_ptr_i,
    input  logic [DATA_WIDTH-1:0]                read_i,
    output logic [ADDR_WIDTH-1:0]                addr_o,
    output logic                                 ena_o,
    output logic                                 wea_o,
    output logic [DATA_WIDTH-1:0]                write_o,
    output logic [1:0]                           rd_mem_ptr_o,
    output logic                                 out_valid_o,
    input  logic                                 out_ready_i,
    output logic [ADDR_WIDTH-1:0]                out_addr_o,
    output logic [17:0]                          out_edges_o,
    output logic [INPUT_DIM-1:0][PRECISION-1:0] out_features_o,
    output logic                                 busy_o,
    output logic                                 frame_done_o,
    output logic                                 overrun_o
);

    localparam int NODES = OUT_GRAPH_SIZE * OUT_GRAPH_SIZE;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NODES - 1);
    localparam int CNT_W = $clog2(FIFO_DEPTH + READ_LATENCY + 2) + 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0]              ptr_q;
    logic [1:0]              rdPtr_q, rdPtr_d;
    logic [ADDR_WIDTH-1:0]   scanAddr_q, scanAddr_d;
    logic                    pending_q, pending_d;
    logic [1:0]              pendTarget_q, pendTarget_d;
    logic [CNT_W-1:0]        inflight_q, inflight_d;
    logic [READ_LATENCY-1:0] tagValid_q;
    logic [ADDR_WIDTH-1:0]   tagAddr_q [READ_LATENCY];
    logic                    stageValid_q;
    logic [ADDR_WIDTH-1:0]   stageAddr_q;
    logic [DATA_WIDTH-1:0]   stageData_q;
    logic [ADDR_WIDTH-1:0]   fifoAddr_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]   fifoData_q [FIFO_DEPTH];
    logic [PTR_W-1:0]        fifoWp_q, fifoRp_q;
    logic [CNT_W-1:0]        fifoCnt_q;

    logic                    trigger;
    logic                    issue;
    logic                    ret;
    logic                    push;
    logic                    pop;
    logic                    drained;
    logic                    startTrig;
    logic                    startPend;
    logic                    frameDone;
    logic                    overrun;
    logic [CNT_W-1:0]        occupancy;
    logic [ADDR_WIDTH-1:0]   headAddr;
    logic [DATA_WIDTH-1:0]   headData;

    // A pointer advance is seen by comparing against the value registered
    // last cycle; the buffer to scan is the one the writer just left.
    assign trigger = (wr_mem_ptr_i != ptr_q);

    // Credits cover words already in the FIFO, reads still in the memory
    // pipeline and the one-word return stage, so the FIFO can never overflow.
    assign occupancy = fifoCnt_q + inflight_q + CNT_W'(stageValid_q);
    assign issue     = (state_q == SCAN) && (occupancy < DEPTH_C);
    assign ret       = tagValid_q[READ_LATENCY-1];
    assign push      = stageValid_q;
    assign pop       = out_valid_o && out_ready_i;
    assign drained   = (inflight_q == '0) && !stageValid_q && (fifoCnt_q == '0);

    // Next-state logic: scan sequencing plus the single-entry pending queue
    // that remembers one pointer advance arriving while a scan is running.
    always_comb begin
        state_d      = state_q;
        rdPtr_d      = rdPtr_q;
        scanAddr_d   = scanAddr_q;
        pending_d    = pending_q;
        pendTarget_d = pendTarget_q;
        frameDone    = 1'b0;
        overrun      = 1'b0;
        startTrig    = 1'b0;
        startPend    = 1'b0;

        case (state_q)
            IDLE: begin
                // An older queued advance goes first so buffer order is kept.
                if (pending_q) begin
                    startPend = 1'b1;
                end else if (trigger) begin
                    startTrig = 1'b1;
                end
            end
            SCAN: begin
                if (issue) begin
                    if (scanAddr_q == LAST_ADDR) begin
                        state_d = DRAIN;
                    end else begin
                        scanAddr_d = scanAddr_q + ADDR_WIDTH'(1);
                    end
                end
            end
            DRAIN: begin
                if (drained) begin
                    frameDone = 1'b1;
                    if (pending_q) begin
                        startPend = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (startPend) begin
            state_d    = SCAN;
            rdPtr_d    = pendTarget_q;
            scanAddr_d = '0;
            pending_d  = 1'b0;
        end
        if (startTrig) begin
            state_d    = SCAN;
            rdPtr_d    = ptr_q;
            scanAddr_d = '0;
        end

        // A queue slot freed this very cycle may be reused immediately.
        if (trigger && !startTrig) begin
            if (pending_q && !startPend) begin
                overrun = 1'b1;
            end else begin
                pending_d    = 1'b1;
                pendTarget_d = ptr_q;
            end
        end
    end

    assign inflight_d = inflight_q + CNT_W'(issue) - CNT_W'(ret);

    // Control state. The writer pointer is sampled during reset too, so the
    // first cycle after reset never sees a spurious advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            ptr_q        <= wr_mem_ptr_i;
            rdPtr_q      <= '0;
            scanAddr_q   <= '0;
            pending_q    <= 1'b0;
            pendTarget_q <= '0;
            inflight_q   <= '0;
            tagValid_q   <= '0;
            stageValid_q <= 1'b0;
            fifoWp_q     <= '0;
            fifoRp_q     <= '0;
            fifoCnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= wr_mem_ptr_i;
            rdPtr_q      <= rdPtr_d;
            scanAddr_q   <= scanAddr_d;
            pending_q    <= pending_d;
            pendTarget_q <= pendTarget_d;
            inflight_q   <= inflight_d;
            tagValid_q[0] <= issue;
            for (int i = 1; i < READ_LATENCY; i++) begin
                tagValid_q[i] <= tagValid_q[i-1];
            end
            // Empty words are cleared in memory but never enter the stream.
            stageValid_q <= ret && read_i[4];
            if (push) begin
                fifoWp_q <= (fifoWp_q == PTR_LAST) ? '0 : fifoWp_q + PTR_W'(1);
            end
            if (pop) begin
                fifoRp_q <= (fifoRp_q == PTR_LAST) ? '0 : fifoRp_q + PTR_W'(1);
            end
            fifoCnt_q <= fifoCnt_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Datapath registers carry no reset; their valid flags above gate them.
    always_ff @(posedge clk) begin
        tagAddr_q[0] <= scanAddr_q;
        for (int i = 1; i < READ_LATENCY; i++) begin
            tagAddr_q[i] <= tagAddr_q[i-1];
        end
        if (ret) begin
            stageAddr_q <= tagAddr_q[READ_LATENCY-1];
            stageData_q <= read_i;
        end
        if (push) begin
            fifoAddr_q[fifoWp_q] <= stageAddr_q;
            fifoData_q[fifoWp_q] <= stageData_q;
        end
    end

    // Stream outputs are forced to zero when nothing is valid so the
    // uninitialised FIFO storage never leaks out after reset.
    assign headAddr       = out_valid_o ? fifoAddr_q[fifoRp_q] : '0;
    assign headData       = out_valid_o ? fifoData_q[fifoRp_q] : '0;
    assign out_valid_o    = (fifoCnt_q != '0);
    assign out_addr_o     = headAddr;
    assign out_edges_o    = headData[17:0];
    assign out_features_o = headData[DATA_WIDTH-1:18];

    assign addr_o       = scanAddr_q;
    assign ena_o        = issue;
    assign wea_o        = issue;
    assign write_o      = '0;
    assign rd_mem_ptr_o = rdPtr_q;
    assign busy_o       = (state_q != IDLE);
    assign frame_done_o = frameDone;
    assign overrun_o    = overrun;

endmodule

// File: tb/tb_sync_pool_readout.sv
// ---------------------------------------------------------------------------
// tb_sync_pool_readout
//
// Directed bench for sync_pool_readout. A behavioural three-buffer READ_FIRST
// memory with two-cycle read latency sits on the memory port; a monitor
// records stream beats, enable counts and stall stability. Each test task
// drives one scenario and checks hand-derived values inline.
// ---------------------------------------------------------------------------
module tb_sync_pool_readout;

    localparam int P  = 16;
    localparam int ID = 32;
    localparam int AW = 8;
    localparam int DW = ID * P + 18;

    logic                   clk;
    logic                   reset;
    logic [1:0]             wrPtr;
    logic [DW-1:0]          readData;
    logic [AW-1:0]          addr;
    logic                   ena;
    logic                   wea;
    logic [DW-1:0]          writeData;
    logic [1:0]             rdPtr;
    logic                   outValid;
    logic                   outReady;
    logic [AW-1:0]          outAddr;
    logic [17:0]            outEdges;
    logic [ID-1:0][P-1:0]   outFeatures;
    logic                   busy;
    logic                   frameDone;
    logic                   overrun;

    int errors = 0;
    int checks = 0;

    sync_pool_readout dut (
        .clk            (clk),
        .reset          (reset),
        .wr_mem_ptr_i   (wrPtr),
        .read_i         (readData),
        .addr_o         (addr),
        .ena_o          (ena),
        .wea_o          (wea),
        .write_o        (writeData),
        .rd_mem_ptr_o   (rdPtr),
        .out_valid_o    (outValid),
        .out_ready_i    (outReady),
        .out_addr_o     (outAddr),
        .out_edges_o    (outEdges),
        .out_features_o (outFeatures),
        .busy_o         (busy),
        .frame_done_o   (frameDone),
        .overrun_o      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Three-buffer memory with a backdoor port for preloading.
    bit [DW-1:0] mem [3][256];
    bit [DW-1:0] rdPipe1, rdPipe2;
    logic        bdWe = 1'b0;
    logic [1:0]  bdBuf = '0;
    logic [AW-1:0] bdAddr = '0;
    logic [DW-1:0] bdData = '0;

    always @(posedge clk) begin
        if (bdWe) begin
            mem[int'(bdBuf)][int'(bdAddr)] <= bdData;
        end else if (ena && rdPtr != 2'd3) begin
            rdPipe1 <= mem[int'(rdPtr)][int'(addr)];
            if (wea) mem[int'(rdPtr)][int'(addr)] <= writeData;
        end
        rdPipe2 <= rdPipe1;
    end
    assign readData = rdPipe2;

    // Monitor: counts and stream capture, sampled on the falling edge.
    int enaCount = 0, weaCount = 0, frameCount = 0, overrunCount = 0, stallViol = 0;
    int beatAddr[$];
    logic [17:0] beatEdges[$];
    logic [P-1:0] beatF0[$];
    logic [P-1:0] beatFL[$];
    bit stallPrev = 1'b0;
    logic [AW-1:0] prevAddr;
    logic [17:0] prevEdges;
    logic [ID-1:0][P-1:0] prevFeat;

    always @(negedge clk) begin
        if (ena) enaCount++;
        if (wea) weaCount++;
        if (frameDone) frameCount++;
        if (overrun) overrunCount++;
        if (reset) begin
            stallPrev = 1'b0;
        end else begin
            if (stallPrev && (outValid !== 1'b1 || outAddr !== prevAddr ||
                              outEdges !== prevEdges || outFeatures !== prevFeat))
                stallViol++;
            if (outValid && outReady) begin
                beatAddr.push_back(int'(outAddr));
                beatEdges.push_back(outEdges);
                beatF0.push_back(outFeatures[0]);
                beatFL.push_back(outFeatures[ID-1]);
            end
            stallPrev = outValid && !outReady;
            prevAddr  = outAddr;
            prevEdges = outEdges;
            prevFeat  = outFeatures;
        end
    end

    function automatic logic [DW-1:0] makeWord(input logic [17:0] e, input logic [P-1:0] v);
        logic [DW-1:0] w;
        w = '0;
        w[17:0] = e;
        for (int f = 0; f < ID; f++) w[18 + P*f +: P] = v;
        return w;
    endfunction

    function automatic logic [ID-1:0][P-1:0] featAll(input logic [P-1:0] v);
        logic [ID-1:0][P-1:0] r;
        for (int f = 0; f < ID; f++) r[f] = v;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [1:0] b, input int a, input logic [DW-1:0] w);
        bdWe = 1'b1; bdBuf = b; bdAddr = AW'(a); bdData = w;
        tick();
        bdWe = 1'b0;
    endtask

    task automatic waitFrames(input int target, input int limit);
        int n = 0;
        while (frameCount < target && n < limit) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; wrPtr = 2'd0; outReady = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        checks++; if (ena !== 1'b0) begin errors++; $display("[TB] FAIL reset_ena: got %0b expected 0", ena); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if (outValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %0b expected 0", outValid); end
        checks++; if (rdPtr !== 2'd0 || addr !== '0) begin errors++; $display("[TB] FAIL reset_ptr_addr: got %0d/%0d expected 0/0", rdPtr, addr); end
        checks++; if (outFeatures !== '0 || outAddr !== '0 || outEdges !== '0) begin errors++; $display("[TB] FAIL reset_outdata: got addr %0h edges %0h expected zeros", outAddr, outEdges); end
        repeat (5) tick();
        checks++; if (enaCount !== 0 || frameDone !== 1'b0 || overrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_quiet: got ena count %0d expected 0", enaCount); end
    endtask

    task automatic test_single_node();
        int e0, f0, b0, n, nz;
        preload(2'd0, 5, makeWord(18'h00010, 16'd7));
        preload(2'd0, 6, makeWord(18'h0000F, 16'd9));
        e0 = enaCount; f0 = frameCount; b0 = beatAddr.size();
        wrPtr = 2'd1;
        tick();
        checks++; if (ena !== 1'b1 || addr !== 8'd0 || rdPtr !== 2'd0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL first_ena: got ena %0b addr %0d ptr %0d expected 1/0/0", ena, addr, rdPtr); end
        n = 1;
        while (!outValid && n < 50) begin tick(); n++; end
        checks++; if (n != 10) begin errors++; $display("[TB] FAIL valid_latency: got %0d expected 10", n); end
        checks++; if (outAddr !== 8'd5 || outEdges !== 18'h00010) begin errors++; $display("[TB] FAIL single_beat: got addr %0d edges %0h expected 5/10", outAddr, outEdges); end
        checks++; if (outFeatures !== featAll(16'd7)) begin errors++; $display("[TB] FAIL single_feat: got %0h expected all 7", outFeatures); end
        waitFrames(f0 + 1, 400);
        repeat (5) tick();
        checks++; if (frameCount - f0 != 1) begin errors++; $display("[TB] FAIL single_frames: got %0d expected 1", frameCount - f0); end
        checks++; if (beatAddr.size() - b0 != 1) begin errors++; $display("[TB] FAIL single_beats: got %0d expected 1", beatAddr.size() - b0); end
        checks++; if (enaCount - e0 != 256) begin errors++; $display("[TB] FAIL single_ena_count: got %0d expected 256", enaCount - e0); end
        nz = 0;
        for (int a = 0; a < 256; a++) if (mem[0][a] != '0) nz++;
        checks++; if (nz != 0) begin errors++; $display("[TB] FAIL single_cleared: got %0d nonzero words expected 0", nz); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL single_idle: got busy %0b expected 0", busy); end
    endtask

    task automatic test_backpressure();
        int e0, f0, b0, s0;
        for (int a = 0; a < 5; a++) preload(2'd1, a, makeWord(18'h10 | 18'(a), 16'(256 + a)));
        e0 = enaCount; f0 = frameCount; b0 = beatAddr.size(); s0 = stallViol;
        outReady = 1'b0;
        wrPtr = 2'd2;
        repeat (20) tick();
        checks++; if (enaCount - e0 != 4) begin errors++; $display("[TB] FAIL bp_stall_ena: got %0d expected 4", enaCount - e0); end
        checks++; if (outValid !== 1'b1 || outAddr !== 8'd0) begin errors++; $display("[TB] FAIL bp_head: got valid %0b addr %0d expected 1/0", outValid, outAddr); end
        checks++; if (rdPtr !== 2'd1 || busy !== 1'b1) begin errors++; $display("[TB] FAIL bp_ptr: got %0d busy %0b expected 1/1", rdPtr, busy); end
        outReady = 1'b1;
        waitFrames(f0 + 1, 600);
        checks++; if (beatAddr.size() - b0 != 5) begin errors++; $display("[TB] FAIL bp_beat_count: got %0d expected 5", beatAddr.size() - b0); end
        for (int i = 0; i < 5 && b0 + i < beatAddr.size(); i++) begin
            checks++;
            if (beatAddr[b0+i] != i || beatEdges[b0+i] !== (18'h10 | 18'(i)) || beatF0[b0+i] !== 16'(256 + i)) begin
                errors++; $display("[TB] FAIL bp_beat%0d: got addr %0d edges %0h f0 %0h expected %0d", i, beatAddr[b0+i], beatEdges[b0+i], beatF0[b0+i], i);
            end
        end
        checks++; if (stallViol != s0) begin errors++; $display("[TB] FAIL bp_stable: got %0d violations expected 0", stallViol - s0); end
        checks++; if (enaCount - e0 != 256) begin errors++; $display("[TB] FAIL bp_ena_total: got %0d expected 256", enaCount - e0); end
    endtask

    task automatic test_empty_buffer();
        int e0, w0, f0, b0;
        e0 = enaCount; w0 = weaCount; f0 = frameCount; b0 = beatAddr.size();
        wrPtr = 2'd0;
        tick(); tick();
        checks++; if (rdPtr !== 2'd2 || busy !== 1'b1) begin errors++; $display("[TB] FAIL empty_ptr: got %0d busy %0b expected 2/1", rdPtr, busy); end
        waitFrames(f0 + 1, 600);
        repeat (3) tick();
        checks++; if (enaCount - e0 != 256 || weaCount - w0 != 256) begin errors++; $display("[TB] FAIL empty_ena_wea: got %0d/%0d expected 256/256", enaCount - e0, weaCount - w0); end
        checks++; if (beatAddr.size() != b0) begin errors++; $display("[TB] FAIL empty_no_beats: got %0d expected 0", beatAddr.size() - b0); end
        checks++; if (frameCount - f0 != 1) begin errors++; $display("[TB] FAIL empty_frames: got %0d expected 1", frameCount - f0); end
    endtask

    task automatic test_pending_overrun();
        int e0, f0, b0, o0;
        for (int a = 0; a < 4; a++) preload(2'd0, a, makeWord(18'h10, 16'(32 + a)));
        e0 = enaCount; f0 = frameCount; b0 = beatAddr.size(); o0 = overrunCount;
        outReady = 1'b0;
        wrPtr = 2'd1;
        repeat (5) tick();
        checks++; if (rdPtr !== 2'd0 || busy !== 1'b1) begin errors++; $display("[TB] FAIL pend_first_ptr: got %0d expected 0", rdPtr); end
        wrPtr = 2'd2;
        repeat (5) tick();
        checks++; if (overrunCount != o0) begin errors++; $display("[TB] FAIL pend_no_overrun: got %0d expected 0", overrunCount - o0); end
        wrPtr = 2'd0;
        repeat (3) tick();
        checks++; if (overrunCount - o0 != 1) begin errors++; $display("[TB] FAIL pend_overrun: got %0d expected 1", overrunCount - o0); end
        outReady = 1'b1;
        waitFrames(f0 + 1, 600);
        checks++; if (rdPtr !== 2'd1 || busy !== 1'b1) begin errors++; $display("[TB] FAIL pend_second_ptr: got %0d busy %0b expected 1/1", rdPtr, busy); end
        waitFrames(f0 + 2, 600);
        repeat (10) tick();
        checks++; if (frameCount - f0 != 2 || busy !== 1'b0) begin errors++; $display("[TB] FAIL pend_frames: got %0d busy %0b expected 2/0", frameCount - f0, busy); end
        checks++; if (beatAddr.size() - b0 != 4 || enaCount - e0 != 512) begin errors++; $display("[TB] FAIL pend_counts: got beats %0d ena %0d expected 4/512", beatAddr.size() - b0, enaCount - e0); end
    endtask

    task automatic test_reset_mid_scan();
        int n, e0, f0;
        preload(2'd0, 200, makeWord(18'h10, 16'h55));
        wrPtr = 2'd1;
        n = 0;
        while (!(ena && addr == 8'd100) && n < 400) begin tick(); n++; end
        checks++; if (!(ena && addr == 8'd100)) begin errors++; $display("[TB] FAIL mid_reach100: got addr %0d expected 100", addr); end
        reset = 1'b1;
        tick();
        checks++; if (ena !== 1'b0 || busy !== 1'b0 || addr !== '0 || rdPtr !== '0 || outValid !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_outputs: got ena %0b busy %0b addr %0d expected 0/0/0", ena, busy, addr); end
        reset = 1'b0;
        tick();
        e0 = enaCount;
        repeat (10) tick();
        checks++; if (enaCount != e0) begin errors++; $display("[TB] FAIL mid_no_ena: got %0d expected 0", enaCount - e0); end
        checks++; if (mem[0][200] != makeWord(18'h10, 16'h55)) begin errors++; $display("[TB] FAIL mid_not_cleared: got %0h expected 55 word", mem[0][200][17:0]); end
        f0 = frameCount;
        wrPtr = 2'd2;
        tick();
        checks++; if (ena !== 1'b1 || addr !== 8'd0 || rdPtr !== 2'd1) begin errors++; $display("[TB] FAIL mid_restart: got ena %0b addr %0d ptr %0d expected 1/0/1", ena, addr, rdPtr); end
        waitFrames(f0 + 1, 600);
        checks++; if (frameCount - f0 != 1) begin errors++; $display("[TB] FAIL mid_frame: got %0d expected 1", frameCount - f0); end
    endtask

    task automatic test_random_ready();
        int f0, b0, s0, n;
        for (int a = 0; a < 256; a += 2) preload(2'd2, a, makeWord(18'h10 | 18'(a & 15), 16'(a * 3 + 1)));
        f0 = frameCount; b0 = beatAddr.size(); s0 = stallViol;
        wrPtr = 2'd0;
        n = 0;
        while (frameCount == f0 && n < 6000) begin
            outReady = ($urandom_range(0, 1) == 1);
            tick();
            n++;
        end
        outReady = 1'b1;
        checks++; if (frameCount == f0) begin errors++; $display("[TB] FAIL rand_timeout: got no frame_done expected 1"); end
        checks++; if (beatAddr.size() - b0 != 128) begin errors++; $display("[TB] FAIL rand_beat_count: got %0d expected 128", beatAddr.size() - b0); end
        for (int i = 0; i < 128 && b0 + i < beatAddr.size(); i++) begin
            checks++;
            if (beatAddr[b0+i] != 2*i || beatEdges[b0+i] !== (18'h10 | 18'((2*i) & 15)) ||
                beatF0[b0+i] !== 16'(6*i + 1) || beatFL[b0+i] !== 16'(6*i + 1)) begin
                errors++; $display("[TB] FAIL rand_beat%0d: got addr %0d f0 %0h expected addr %0d f0 %0h", i, beatAddr[b0+i], beatF0[b0+i], 2*i, 16'(6*i + 1));
            end
        end
        checks++; if (stallViol != s0) begin errors++; $display("[TB] FAIL rand_stable: got %0d violations expected 0", stallViol - s0); end
    endtask

    initial begin
        reset = 1'b1; wrPtr = 2'd0; outReady = 1'b1;
        test_reset();
        test_single_node();
        test_backpressure();
        test_empty_buffer();
        test_pending_overrun();
        test_reset_mid_scan();
        test_random_ready();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
